seg7_scan: RTL and testbench
============================

# seg7_scan

Parametrised multiplexed seven-segment display driver for the board-level top modules. It scans `DIGITS` common-anode/cathode digits from a packed hex value with per-digit decimal point and blanking, and inserts an anti-ghosting blank interval between digits. Input data is snapshotted once per frame, so the display never tears. It replaces hard-wired `DS_*` assigns and sits between CPU GPIO / debug registers and the display pins, clocked from the divided system clock.

## Interface
- `DIGITS`, 4: number of digits scanned; must be ≥1.
- `SYS_CLK`, 1000000: `clk` frequency in Hz.
- `SCAN_HZ`, 1000: digit-slot rate in Hz; `TICK_DIV = SYS_CLK/SCAN_HZ` cycles per slot; must satisfy `TICK_DIV > BLANK_CYCLES`.
- `BLANK_CYCLES`, 4: cycles at the start of each slot with all digit enables inactive; 0 is legal.
- `SEG_ACTIVE_LOW`, 1: 1 means segment outputs are driven low to light.
- `EN_ACTIVE_LOW`, 1: 1 means digit enables are driven low to select.
- `LZ_SUPPRESS`, 0: 1 blanks leading zero digits (digit 0 is never suppressed).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `value`  in  4*DIGITS  hex nibbles; nibble i = `value[4i+3:4i]`; digit 0 is least significant.
- `dp`  in  DIGITS  decimal point per digit.
- `blank`  in  DIGITS  force digit i dark.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, polarity per `SEG_ACTIVE_LOW`.
- `seg_dp`  out  1  decimal point segment, same polarity as `seg`.
- `dig_en`  out  DIGITS  one-hot digit select, polarity per `EN_ACTIVE_LOW`.
- `frame`  out  1  one-cycle pulse when a new snapshot is taken.

## Operation
- Counters: `cnt` runs 0..TICK_DIV-1; `idx` runs 0..DIGITS-1 and advances when `cnt` wraps. `idx` wraps from DIGITS-1 to 0.
- Snapshot: on every cycle with `cnt==0 && idx==0`, `value`, `dp` and `blank` are latched into shadow registers, and `frame` pulses for that cycle. The effective blank mask is computed from the new data at the same time (see LZ below). Input changes at any other time have no effect until the next frame.
- LZ suppression (`LZ_SUPPRESS=1`): digit i>0 is blanked when its nibble and all higher nibbles are 0. Example: 4 digits, 0x0050 → digits 3 and 2 are dark. `value=0` shows a single "0".
- Slot phases (FSM `BLANK`→`DRIVE`):
  - `BLANK` while `cnt < BLANK_CYCLES`.
  - `DRIVE` for the remainder of the slot.
  - `BLANK_CYCLES=0` means the FSM is always in `DRIVE`.
- In `DRIVE`, if digit `idx` is not blanked:
  - the `dig_en` bit for `idx` is active;
  - `seg` = hex decode of shadow nibble `idx`;
  - `seg_dp` = shadow `dp[idx]`.
- In `BLANK`, or for a blanked digit: all `dig_en` bits, `seg` and `seg_dp` are inactive.
- Hex decode uses the standard 0–F glyphs, with lowercase b and d. Example: 0 = a,b,c,d,e,f; 7 = a,b,c; F = a,e,f,g.
- All outputs are registered, with no combinational path from input to output.
- Reset (asynchronous, any time, including mid-slot):
  - `cnt=0`, `idx=0`, shadows=0;
  - `frame=0`;
  - all `dig_en`, `seg` and `seg_dp` at inactive level.
  - Operation resumes on the first edge after release.

## Timing
- On the first rising edge after reset release, the snapshot is taken and `frame` goes high. `frame` is high exactly 1 cycle per frame.
- Frame period is `DIGITS*TICK_DIV` cycles.
- Output latency is 1 cycle from counter state. Digit i's enable is active for `TICK_DIV-BLANK_CYCLES` consecutive cycles, starting `BLANK_CYCLES+1` cycles after its slot's `cnt==0` edge.
- Digit enables never overlap. With `BLANK_CYCLES≥1`, at least `BLANK_CYCLES` all-inactive cycles separate consecutive digits.
- Inputs need only be stable on the snapshot edge. Data changed in the same cycle as the snapshot is captured.

## Structure
- Include file `seg7_defs.vh`:
  - segment bit-index localparams (`SEG_A`..`SEG_G`);
  - the 16-entry glyph constant table, shared with other display users.
- Sub-module `seg7_decode`: purely combinational nibble→7-bit glyph, active-high; `seg7_scan` applies polarity.
- Width of `cnt` is `$clog2(TICK_DIV)`. Width of `idx` is `$clog2(DIGITS)`, with a minimum of 1.

## Test plan
All scenarios use `DIGITS=4`, `SYS_CLK=1000`, `SCAN_HZ=100` (`TICK_DIV=10`) and `BLANK_CYCLES=2`, except where stated otherwise.
- **Reset:** assert `reset` mid-slot → outputs inactive immediately (`dig_en=4'hF`, `seg=7'h7F`); release → `frame` high on edge 1, then every 40 cycles.
- **Scan:** `value=16'h1234`, `dp=4'b0010`:
  - digit 0 shows 4 (`seg` active bits b,c,f,g) for 8 cycles after 2 dark cycles;
  - digit 1 shows 3 with `seg_dp` active;
  - order is 0,1,2,3, then it repeats.
- **No tearing:** change `value` to `16'hABCD` mid-frame → old digits are finished; new value appears only after the next `frame` pulse.
- **Blank/LZ:**
  - `LZ_SUPPRESS=1`, `value=16'h0050` → digits 3 and 2 are never enabled; digits 1 and 0 show 5 and 0.
  - `value=0` → only digit 0 is enabled.
  - `blank=4'b0001` → digit 0 is dark.
- **Polarity/edge params:** `SEG_ACTIVE_LOW=0`, `EN_ACTIVE_LOW=0`, `BLANK_CYCLES=0` → enables are active-high, one-hot, gap-free with 10-cycle slots; glyph 8 gives `seg=7'h7F`.

Source files
------------

// File: rtl/seg7_scan_pkg.sv
// rtl/seg7_scan_pkg.sv - shared segment indices, glyph table and slot-phase type for seg7_scan
package seg7_scan_pkg;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-high {g,f,e,d,c,b,a}; entry 15 first. Lowercase b and d.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } slot_state_e;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex nibble to active-high seven-segment glyph
module seg7_decode
    import seg7_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] glyph_o
);

    assign glyph_o = GLYPH_TABLE[nibble_i];

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed seven-segment scanner with per-frame snapshot and anti-ghost blanking
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SYS_CLK        = 1000000,
    parameter int SCAN_HZ        = 1000,
    parameter int BLANK_CYCLES   = 4,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EN_ACTIVE_LOW  = 1,
    parameter int LZ_SUPPRESS    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     dig_en,
    output logic                  frame
);

    localparam int TICK_DIV = SYS_CLK / SCAN_HZ;
    localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic              SEG_DP_OFF = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] EN_OFF     = (EN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] val_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   mask_q;
    slot_state_e         state_q, state_d;
    logic [6:0]          seg_q;
    logic                seg_dp_q;
    logic [DIGITS-1:0]   dig_en_q;
    logic                frame_q;

    logic                snap;
    logic                in_drive;
    logic                seen_nz;
    logic [DIGITS-1:0]   lz_mask;
    logic [DIGITS-1:0]   mask_new;
    logic [4*DIGITS-1:0] val_cur;
    logic [DIGITS-1:0]   dp_cur;
    logic [DIGITS-1:0]   mask_cur;
    logic [DIGITS-1:0]   en_hot;
    logic [6:0]          glyph;

    assign snap  = (cnt_q == '0) && (idx_q == '0);
    assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    assign idx_d = (cnt_q != CNT_LAST) ? idx_q :
                   (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    generate
        if (BLANK_CYCLES == 0) begin : g_no_blank
            assign in_drive = 1'b1;
        end else begin : g_blank
            assign in_drive = (cnt_q >= CNT_W'(BLANK_CYCLES));
        end
    endgenerate

    assign state_d = in_drive ? ST_DRIVE : ST_BLANK;

    // A digit is a leading zero when it and every higher nibble are zero; digit 0 always shows.
    always_comb begin
        lz_mask = '0;
        seen_nz = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (value[4*i +: 4] != 4'h0) seen_nz = 1'b1;
            lz_mask[i] = ~seen_nz;
        end
    end

    assign mask_new = (LZ_SUPPRESS != 0) ? (blank | lz_mask) : blank;

    // On the snapshot edge the slot being entered must already use the freshly captured data.
    assign val_cur  = snap ? value    : val_q;
    assign dp_cur   = snap ? dp       : dp_q;
    assign mask_cur = snap ? mask_new : mask_q;
    assign en_hot   = DIGITS'(1) << idx_q;

    seg7_decode u_decode (
        .nibble_i (val_cur[4*idx_q +: 4]),
        .glyph_o  (glyph)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            val_q    <= '0;
            dp_q     <= '0;
            mask_q   <= '0;
            state_q  <= ST_BLANK;
            seg_q    <= SEG_OFF;
            seg_dp_q <= SEG_DP_OFF;
            dig_en_q <= EN_OFF;
            frame_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            frame_q <= snap;
            state_q <= state_d;
            if (snap) begin
                val_q  <= value;
                dp_q   <= dp;
                mask_q <= mask_new;
            end
            case (state_d)
                ST_DRIVE: begin
                    if (!mask_cur[idx_q]) begin
                        seg_q    <= glyph ^ SEG_OFF;
                        seg_dp_q <= dp_cur[idx_q] ^ SEG_DP_OFF;
                        dig_en_q <= en_hot ^ EN_OFF;
                    end else begin
                        seg_q    <= SEG_OFF;
                        seg_dp_q <= SEG_DP_OFF;
                        dig_en_q <= EN_OFF;
                    end
                end
                default: begin
                    seg_q    <= SEG_OFF;
                    seg_dp_q <= SEG_DP_OFF;
                    dig_en_q <= EN_OFF;
                end
            endcase
        end
    end

    assign seg    = seg_q;
    assign seg_dp = seg_dp_q;
    assign dig_en = dig_en_q;
    assign frame  = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - randomized self-checking bench for seg7_scan against a frame/slot reference model
module tb_seg7_scan;

    localparam int D     = 4;
    localparam int T     = 10;
    localparam int FRAME = D * T;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;

    logic [6:0] seg_a, seg_b, seg_c;
    logic       sdp_a, sdp_b, sdp_c;
    logic [3:0] en_a, en_b, en_c;
    logic       fr_a, fr_b, fr_c;

    always #5 clk = ~clk;

    seg7_scan #(.DIGITS(4), .SYS_CLK(1000), .SCAN_HZ(100), .BLANK_CYCLES(2),
                .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1), .LZ_SUPPRESS(0)) u_a (
        .clk(clk), .reset(reset), .value(value), .dp(dp), .blank(blank),
        .seg(seg_a), .seg_dp(sdp_a), .dig_en(en_a), .frame(fr_a));

    seg7_scan #(.DIGITS(4), .SYS_CLK(1000), .SCAN_HZ(100), .BLANK_CYCLES(2),
                .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1), .LZ_SUPPRESS(1)) u_b (
        .clk(clk), .reset(reset), .value(value), .dp(dp), .blank(blank),
        .seg(seg_b), .seg_dp(sdp_b), .dig_en(en_b), .frame(fr_b));

    seg7_scan #(.DIGITS(4), .SYS_CLK(1000), .SCAN_HZ(100), .BLANK_CYCLES(0),
                .SEG_ACTIVE_LOW(0), .EN_ACTIVE_LOW(0), .LZ_SUPPRESS(0)) u_c (
        .clk(clk), .reset(reset), .value(value), .dp(dp), .blank(blank),
        .seg(seg_c), .seg_dp(sdp_c), .dig_en(en_c), .frame(fr_c));

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;
    logic [15:0] sh_val;
    logic [3:0]  sh_dp;
    logic [3:0]  sh_blank;

    string seg_names [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                              "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        string s;
        int pos;
        g = '0;
        s = seg_names[n];
        for (int i = 0; i < s.len(); i++) begin
            pos = int'(s[i]) - 97;
            g[pos] = 1'b1;
        end
        return g;
    endfunction

    task automatic check_inst(input string nm, input bit lz, input int bc, input bit seg_low,
                              input bit en_low, input logic [6:0] s, input logic sd,
                              input logic [3:0] en, input logic fr);
        int p, slot, c;
        logic [3:0] dark;
        bit on;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_en;
        p    = (k - 1) % FRAME;
        slot = p / T;
        c    = p % T;
        dark = sh_blank;
        if (lz)
            for (int i = 1; i < D; i++)
                if ((sh_val >> (4 * i)) == 16'h0) dark[i] = 1'b1;
        on    = (c >= bc) && !dark[slot];
        e_seg = on ? glyph(sh_val[4*slot +: 4]) : 7'h00;
        e_dp  = on && sh_dp[slot];
        e_en  = on ? (4'b0001 << slot) : 4'b0000;
        if (seg_low) begin
            e_seg = ~e_seg;
            e_dp  = ~e_dp;
        end
        if (en_low) e_en = ~e_en;
        expect_eq({nm, ".seg"},    32'(s),  32'(e_seg));
        expect_eq({nm, ".seg_dp"}, 32'(sd), 32'(e_dp));
        expect_eq({nm, ".dig_en"}, 32'(en), 32'(e_en));
        expect_eq({nm, ".frame"},  32'(fr), 32'(p == 0));
    endtask

    task automatic check_idle(input string tag);
        expect_eq({tag, ".a.dig_en"}, 32'(en_a),  32'h0000_000F);
        expect_eq({tag, ".a.seg"},    32'(seg_a), 32'h0000_007F);
        expect_eq({tag, ".a.seg_dp"}, 32'(sdp_a), 32'h1);
        expect_eq({tag, ".a.frame"},  32'(fr_a),  32'h0);
        expect_eq({tag, ".b.dig_en"}, 32'(en_b),  32'h0000_000F);
        expect_eq({tag, ".c.dig_en"}, 32'(en_c),  32'h0);
        expect_eq({tag, ".c.seg"},    32'(seg_c), 32'h0);
        expect_eq({tag, ".c.frame"},  32'(fr_c),  32'h0);
    endtask

    // Entered and left at a negedge; inputs only ever change there.
    task automatic run(input int cycles, input bit rnd);
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            k++;
            if ((k - 1) % FRAME == 0) begin
                sh_val   = value;
                sh_dp    = dp;
                sh_blank = blank;
            end
            @(negedge clk);
            check_inst("a", 1'b0, 2, 1'b1, 1'b1, seg_a, sdp_a, en_a, fr_a);
            check_inst("b", 1'b1, 2, 1'b1, 1'b1, seg_b, sdp_b, en_b, fr_b);
            check_inst("c", 1'b0, 0, 1'b0, 1'b0, seg_c, sdp_c, en_c, fr_c);
            if (rnd && $urandom_range(0, 5) == 0) begin
                value = 16'($urandom) >> $urandom_range(0, 15);
                dp    = 4'($urandom);
                blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            end
        end
    endtask

    task automatic reset_mid_slot();
        #2 reset = 1'b1;
        #1 check_idle("rst_async");
        @(negedge clk);
        check_idle("rst_held");
        reset = 1'b0;
        k = 0;
    endtask

    initial begin
        value = 16'h1234;
        dp    = 4'b0010;
        blank = 4'b0000;
        repeat (2) @(negedge clk);
        check_idle("rst_init");
        reset = 1'b0;

        run(2 * FRAME, 1'b0);
        run(FRAME + 13, 1'b0);
        value = 16'hABCD;
        run(2 * FRAME, 1'b0);
        value = 16'h0050;
        dp    = 4'b0000;
        run(2 * FRAME, 1'b0);
        value = 16'h0000;
        run(2 * FRAME, 1'b0);
        value = 16'h1234;
        blank = 4'b0001;
        run(2 * FRAME, 1'b0);
        value = 16'h8888;
        blank = 4'b0000;
        dp    = 4'b1111;
        run(2 * FRAME, 1'b0);
        run(15 * FRAME + 7, 1'b1);
        reset_mid_slot();
        run(15 * FRAME, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
